// File: rtl/motor_sequencer_if.sv
// Command and motor-pin bundle between the keyboard decoder (master) and motor_sequencer (slave).
interface motor_sequencer_if #(
    parameter int PWM_BITS = 8
);
    logic [1:0]          drive;
    logic [1:0]          direc;
    logic [1:0]          in_l;
    logic [1:0]          in_r;
    logic                pwm_l;
    logic                pwm_r;
    logic [PWM_BITS-1:0] duty;
    logic [1:0]          state;

    modport master (
        output drive, direc,
        input  in_l, in_r, pwm_l, pwm_r, duty, state
    );

    modport slave (
        input  drive, direc,
        output in_l, in_r, pwm_l, pwm_r, duty, state
    );
endinterface

// File: rtl/motor_sequencer.sv
// H-bridge sequencer: soft-start/stop duty ramps, coast dead-time before reversal, inner-wheel steering.
//   state | meaning
//   STOP  | bridges coast, duty 0, waiting for a drive command
//   RUN   | driving in dir_q, duty ramps up to MAX_DUTY
//   BRAKE | duty ramps down; returns to RUN if the command comes back
//   DEAD  | coasting for DEAD_TICKS ramp ticks before STOP
module motor_sequencer #(
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 390,
    parameter int RAMP_DIV   = 100000,
    parameter int RAMP_STEP  = 8,
    parameter int MAX_DUTY   = 255,
    parameter int TURN_SHIFT = 2,
    parameter int DEAD_TICKS = 50
) (
    input logic               clk,
    input logic               rst,
    motor_sequencer_if.slave  bus
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RD_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DC_W = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BRAKE = 2'b10,
        ST_DEAD  = 2'b11
    } state_e;

    localparam logic [1:0] BR_COAST = 2'b00;
    localparam logic [1:0] BR_FWD   = 2'b10;
    localparam logic [1:0] BR_REV   = 2'b01;

    state_e              state_q, state_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_rev_q, dir_rev_d;
    logic [DC_W-1:0]     dead_q, dead_d;
    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [RD_W-1:0]     ramp_q, ramp_d;
    logic [1:0]          bridge_q, bridge_d;
    logic                pwm_l_q, pwm_l_d;
    logic                pwm_r_q, pwm_r_d;

    logic                presc_wrap;
    logic                ramp_tick;
    logic                tgt_fwd, tgt_rev, tgt_match;
    logic [PWM_BITS:0]   duty_sum;
    logic [PWM_BITS-1:0] duty_up, duty_dn;
    logic [PWM_BITS-1:0] duty_l, duty_r;

    assign presc_wrap = (presc_q == PS_W'(PRESCALE - 1));
    assign ramp_tick  = (ramp_q == RD_W'(RAMP_DIV - 1));
    assign presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    assign pwm_cnt_d  = presc_wrap ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    assign ramp_d     = ramp_tick ? '0 : ramp_q + 1'b1;

    assign tgt_fwd   = (bus.drive == 2'b10);
    assign tgt_rev   = (bus.drive == 2'b01);
    assign tgt_match = dir_rev_q ? tgt_rev : tgt_fwd;

    // One spare bit so the saturating add cannot wrap before the ceiling compare.
    assign duty_sum = {1'b0, duty_q} + (PWM_BITS + 1)'(RAMP_STEP);
    assign duty_up  = (duty_sum > (PWM_BITS + 1)'(MAX_DUTY)) ? PWM_BITS'(MAX_DUTY)
                                                             : duty_sum[PWM_BITS-1:0];
    assign duty_dn  = ({1'b0, duty_q} < (PWM_BITS + 1)'(RAMP_STEP)) ? '0
                                                                    : duty_q - PWM_BITS'(RAMP_STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_STOP;
            duty_q    <= '0;
            dir_rev_q <= 1'b0;
            dead_q    <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            ramp_q    <= '0;
            bridge_q  <= BR_COAST;
            pwm_l_q   <= 1'b0;
            pwm_r_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            dir_rev_q <= dir_rev_d;
            dead_q    <= dead_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            ramp_q    <= ramp_d;
            bridge_q  <= bridge_d;
            pwm_l_q   <= pwm_l_d;
            pwm_r_q   <= pwm_r_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        dir_rev_d = dir_rev_q;
        dead_d    = dead_q;
        case (state_q)
            ST_STOP: begin
                duty_d = '0;
                if (tgt_fwd || tgt_rev) begin
                    dir_rev_d = tgt_rev;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!tgt_match)     state_d = ST_BRAKE;
                else if (ramp_tick) duty_d  = duty_up;
            end
            ST_BRAKE: begin
                if (tgt_match) begin
                    state_d = ST_RUN;
                end else if (duty_q == '0) begin
                    state_d = ST_DEAD;
                    dead_d  = '0;
                end else if (ramp_tick) begin
                    duty_d = duty_dn;
                end
            end
            ST_DEAD: begin
                if (dead_q == DC_W'(DEAD_TICKS)) state_d = ST_STOP;
                else if (ramp_tick)              dead_d  = dead_q + 1'b1;
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Bridge follows the next state so it changes on the same edge as the state register.
    always_comb begin
        duty_l   = (bus.direc == 2'b10) ? (duty_q >> TURN_SHIFT) : duty_q;
        duty_r   = (bus.direc == 2'b01) ? (duty_q >> TURN_SHIFT) : duty_q;
        pwm_l_d  = (pwm_cnt_q < duty_l);
        pwm_r_d  = (pwm_cnt_q < duty_r);
        bridge_d = BR_COAST;
        if (state_d == ST_RUN || state_d == ST_BRAKE)
            bridge_d = dir_rev_d ? BR_REV : BR_FWD;
    end

    assign bus.in_l  = bridge_q;
    assign bus.in_r  = bridge_q;
    assign bus.pwm_l = pwm_l_q;
    assign bus.pwm_r = pwm_r_q;
    assign bus.duty  = duty_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_motor_sequencer.sv
// Randomized bench for motor_sequencer against an arithmetic reference model, plus directed PWM and reversal checks.
module tb_motor_sequencer;
    localparam int PWM_BITS   = 8;
    localparam int PRESCALE   = 1;
    localparam int RAMP_DIV   = 4;
    localparam int RAMP_STEP  = 64;
    localparam int MAX_DUTY   = 255;
    localparam int TURN_SHIFT = 2;
    localparam int DEAD_TICKS = 2;

    logic clk;
    logic rst;

    motor_sequencer_if #(.PWM_BITS(PWM_BITS)) bus_if ();

    motor_sequencer #(
        .PWM_BITS  (PWM_BITS),
        .PRESCALE  (PRESCALE),
        .RAMP_DIV  (RAMP_DIV),
        .RAMP_STEP (RAMP_STEP),
        .MAX_DUTY  (MAX_DUTY),
        .TURN_SHIFT(TURN_SHIFT),
        .DEAD_TICKS(DEAD_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: mode 0 STOP, 1 RUN, 2 BRAKE, 3 DEAD; dir +1 forward, -1 reverse.
    int m_k, m_mode, m_dir, m_duty, m_dead, m_br, m_pl, m_pr;

    // Reversal monitor state.
    int last_nz, zero_ticks, prev_b;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_mode = 0; m_dir = 1; m_duty = 0; m_dead = 0;
        m_br = 0; m_pl = 0; m_pr = 0;
    endtask

    function automatic int bridge_code(input int mode, input int dir);
        if (mode == 1 || mode == 2) return (dir > 0) ? 2 : 1;
        return 0;
    endfunction

    task automatic cycle();
        int  tgt, dl, dr, cnt, b;
        bit  tick;
        @(posedge clk);
        tick = ((m_k % RAMP_DIV) == RAMP_DIV - 1);
        if (rst) begin
            model_reset();
            last_nz = 0; zero_ticks = 0;
        end else begin
            cnt = (m_k / PRESCALE) % 256;
            dl  = (bus_if.direc == 2'b10) ? (m_duty >> TURN_SHIFT) : m_duty;
            dr  = (bus_if.direc == 2'b01) ? (m_duty >> TURN_SHIFT) : m_duty;
            m_pl = (cnt < dl) ? 1 : 0;
            m_pr = (cnt < dr) ? 1 : 0;
            tgt = (bus_if.drive == 2'b10) ? 1 : (bus_if.drive == 2'b01) ? -1 : 0;
            case (m_mode)
                0: begin
                    m_duty = 0;
                    if (tgt != 0) begin m_dir = tgt; m_mode = 1; end
                end
                1: begin
                    if (tgt != m_dir) m_mode = 2;
                    else if (tick) m_duty = (m_duty + RAMP_STEP > MAX_DUTY) ? MAX_DUTY : m_duty + RAMP_STEP;
                end
                2: begin
                    if (tgt == m_dir) m_mode = 1;
                    else if (m_duty == 0) begin m_mode = 3; m_dead = 0; end
                    else if (tick) m_duty = (m_duty < RAMP_STEP) ? 0 : m_duty - RAMP_STEP;
                end
                default: begin
                    if (m_dead == DEAD_TICKS) m_mode = 0;
                    else if (tick) m_dead++;
                end
            endcase
            m_br = bridge_code(m_mode, m_dir);
            m_k++;
        end
        #1;
        check("state", bus_if.state, m_mode);
        check("duty",  bus_if.duty,  m_duty);
        check("in_l",  bus_if.in_l,  m_br);
        check("in_r",  bus_if.in_r,  m_br);
        check("pwm_l", bus_if.pwm_l, m_pl);
        check("pwm_r", bus_if.pwm_r, m_pr);
        if (!rst) begin
            b = int'(bus_if.in_l);
            if (prev_b == 0 && tick) zero_ticks++;
            if (b != 0) begin
                if (last_nz != 0 && b != last_nz)
                    check("reverse_dead_time", (zero_ticks >= DEAD_TICKS) ? 1 : 0, 1);
                last_nz = b;
                zero_ticks = 0;
            end
            prev_b = b;
        end else begin
            prev_b = 0;
        end
    endtask

    task automatic wait_mode(input int tgt, input int budget);
        for (int i = 0; i < budget && m_mode != tgt; i++) cycle();
        check($sformatf("reach_state_%0d", tgt), bus_if.state, tgt);
    endtask

    task automatic count_pwm(input string tag, input int exp_l, input int exp_r);
        int hl, hr;
        hl = 0; hr = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (bus_if.pwm_l) hl++;
            if (bus_if.pwm_r) hr++;
        end
        check({tag, "_pwm_l_high"}, hl, exp_l);
        check({tag, "_pwm_r_high"}, hr, exp_r);
    endtask

    initial begin
        int seg_len;
        int pick;
        model_reset();
        last_nz = 0; zero_ticks = 0; prev_b = 0;
        rst = 1'b1;
        bus_if.drive = 2'b00;
        bus_if.direc = 2'b00;
        repeat (2) cycle();
        rst = 1'b0;

        // Forward soft-start to full duty, then steering duty split both ways.
        bus_if.drive = 2'b10;
        cycle();
        check("run_after_cmd", bus_if.state, 1);
        for (int i = 0; i < 40 && m_duty != MAX_DUTY; i++) cycle();
        check("ramp_to_max", bus_if.duty, MAX_DUTY);
        bus_if.direc = 2'b10;
        count_pwm("left_turn", 63, 255);
        bus_if.direc = 2'b01;
        count_pwm("right_turn", 255, 63);
        bus_if.direc = 2'b00;

        // Reversal goes through the whole brake/dead/stop path.
        bus_if.drive = 2'b01;
        wait_mode(3, 100);
        wait_mode(0, 40);
        wait_mode(1, 10);
        check("rev_bridge", bus_if.in_l, 1);

        // drive=11 counts as stop; reset pulsed in DEAD.
        for (int i = 0; i < 20; i++) cycle();
        bus_if.drive = 2'b11;
        wait_mode(2, 5);
        wait_mode(3, 100);
        rst = 1'b1;
        cycle();
        check("rst_in_dead_state", bus_if.state, 0);
        rst = 1'b0;

        // Random command segments with occasional resets.
        for (int seg = 0; seg < 150; seg++) begin
            pick = $urandom_range(0, 9);
            bus_if.drive = (pick < 4) ? 2'b10 : (pick < 8) ? 2'b01 : (pick == 8) ? 2'b00 : 2'b11;
            seg_len = $urandom_range(1, 50);
            for (int i = 0; i < seg_len; i++) begin
                if ($urandom_range(0, 7) == 0) bus_if.direc = 2'($urandom_range(0, 3));
                rst = ($urandom_range(0, 599) == 0);
                cycle();
                rst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/motor_sequencer.md
Name: motor_sequencer

Overview:
- Converts the decoded drive/steer commands (`drive[1:0]`, `direc[1:0]`: 2'b10 = forward/left, 2'b01 = back/right, else none) into H-bridge control for the left and right motors.
- Sequences soft-start and soft-stop duty ramps and enforces a coast dead-time before any direction reversal.
- Steers by reducing inner-wheel duty.
- Sits between the keyboard command decoder and the motor-driver pins.

Parameters:
- PWM_BITS, 8, width of duty and PWM counter.
- PRESCALE, 390, clk cycles per PWM counter step (100 MHz -> ~1 kHz PWM).
- RAMP_DIV, 100000, clk cycles per ramp tick (1 ms).
- RAMP_STEP, 8, duty change per ramp tick.
- MAX_DUTY, 255, duty ceiling; must be <= 2^PWM_BITS-1.
- TURN_SHIFT, 2, inner-wheel duty = duty >> TURN_SHIFT while turning.
- DEAD_TICKS, 50, ramp ticks spent coasting in DEAD.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- drive  in  2  10 = forward, 01 = reverse, 00/11 = stop.
- direc  in  2  10 = left, 01 = right, 00/11 = straight.
- in_l  out  2  left bridge inputs: 10 = fwd, 01 = rev, 00 = coast.
- in_r  out  2  right bridge inputs, same encoding.
- pwm_l  out  1  left enable PWM.
- pwm_r  out  1  right enable PWM.
- duty  out  PWM_BITS  current common duty.
- state  out  2  00 STOP, 01 RUN, 10 BRAKE, 11 DEAD.

Behaviour:
- Single clock, synchronous active-high reset. All outputs are registered.
- Reset values: state = STOP, duty = 0, dir_q = FWD, in_l = in_r = 00, pwm_l = pwm_r = 0, all counters = 0.
- Prescaler: 0..PRESCALE-1, free-running. pwm_cnt (PWM_BITS wide) increments on prescaler wrap and wraps naturally.
- Ramp counter: 0..RAMP_DIV-1, free-running. ramp_tick is a 1-cycle pulse when the counter equals RAMP_DIV-1.
- Target decode: drive 10 -> FWD, 01 -> REV, any other value -> NONE.
- STOP:
  - duty = 0, bridges 00.
  - Target FWD/REV: latch dir_q = target, next state RUN.
- RUN:
  - On ramp_tick: duty = min(duty + RAMP_STEP, MAX_DUTY). Compute with one extra bit to avoid overflow.
  - Target NONE or target != dir_q: next state BRAKE. This takes priority over a same-cycle increment, so no increment occurs that cycle.
- BRAKE:
  - On ramp_tick: duty = max(duty - RAMP_STEP, 0).
  - Target == dir_q: return to RUN, keeping the current duty.
  - Else if duty == 0: go to DEAD and clear dead_cnt.
- DEAD:
  - Bridges 00, PWM 0.
  - dead_cnt increments on each ramp_tick. When dead_cnt == DEAD_TICKS, go to STOP.
  - Commands are ignored in DEAD.
- Bridge outputs:
  - In RUN/BRAKE, both in_l and in_r = (dir_q == FWD) ? 10 : 01.
  - In STOP/DEAD, both = 00.
- Wheel duty:
  - direc 10: duty_l = duty >> TURN_SHIFT, duty_r = duty.
  - direc 01: mirrored.
  - Otherwise both = duty.
  - Steering is applied combinationally each cycle and never changes state.
- PWM: pwm_x = (pwm_cnt < duty_x), registered, so output lags pwm_cnt by 1 cycle. Duty 0 -> constant 0.
- Reversal path is always RUN -> BRAKE -> DEAD -> STOP -> RUN. The bridge never switches 10 <-> 01 without at least DEAD_TICKS ticks of 00.
- Reset asserted mid-operation returns to reset values on the next edge, regardless of state.

Test Plan (PRESCALE=1, RAMP_DIV=4, RAMP_STEP=64, MAX_DUTY=255, DEAD_TICKS=2, TURN_SHIFT=2):
1. Reset, drive=10 held:
   - Next cycle state=RUN, in_l=in_r=10.
   - duty steps 64, 128, 192, 255 on successive ramp_ticks, then stays 255.
2. From duty 255, drive=00:
   - state=BRAKE; duty 191, 127, 63, 0 per tick.
   - Then DEAD, in_x=00 for 2 ticks, then STOP.
3. At duty 128 forward, drive=01:
   - BRAKE down to 0, then DEAD.
   - Bridges are never 01 before DEAD completes.
   - Then STOP -> RUN with in_x=01, ramping from 0.
4. In BRAKE at duty 128, drive returns to 10:
   - Next cycle RUN, duty resumes rising from 128.
5. RUN at duty 255 with direc=10:
   - duty_l=63, so pwm_l is high 63 of every 256 cycles and pwm_r high 255 of 256.
   - direc=01 swaps the two.
6. drive=11 -> treated as stop (BRAKE).
   - rst pulsed while in DEAD -> all outputs return to reset values next cycle.
